// File: rtl/inlet_dose_sequencer_if.sv
// inlet_dose_sequencer_if: command/duration inputs and valve/status outputs of the dose sequencer
interface inlet_dose_sequencer_if #(
  parameter int DUR_W = 16
);
  logic             start;
  logic             abort;
  logic [DUR_W-1:0] dur1;
  logic [DUR_W-1:0] dur2;
  logic [DUR_W-1:0] dur3;
  logic [DUR_W-1:0] settle;
  logic             valve_soln1;
  logic             valve_soln2;
  logic             valve_soln3;
  logic             sample_strobe;
  logic             busy;
  logic             done;
  logic             aborted;
  modport master (
    output start, abort, dur1, dur2, dur3, settle,
    input  valve_soln1, valve_soln2, valve_soln3, sample_strobe, busy, done, aborted
  );
  modport slave (
    input  start, abort, dur1, dur2, dur3, settle,
    output valve_soln1, valve_soln2, valve_soln3, sample_strobe, busy, done, aborted
  );
endinterface

// File: rtl/inlet_dose_sequencer.sv
// inlet_dose_sequencer: timed soln1/soln2/soln3 dosing, settle wait and one-cycle out-port sample
module inlet_dose_sequencer #(
  parameter int DUR_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  inlet_dose_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DOSE1, DOSE2, DOSE3, SETTLE, SAMPLE} state_t;
  state_t           state, nxt;
  logic [DUR_W-1:0] cnt, nxt_cnt;
  logic [DUR_W-1:0] d1, d2, d3, ds;
  logic [DUR_W-1:0] a, b, c, s;
  logic             accept;
  function automatic state_t first_phase(state_t from, logic [DUR_W-1:0] p1, p2, p3, p4);
    return (from < DOSE1 && p1 != '0) ? DOSE1 :
           (from < DOSE2 && p2 != '0) ? DOSE2 :
           (from < DOSE3 && p3 != '0) ? DOSE3 :
           (from < SETTLE && p4 != '0) ? SETTLE : SAMPLE;
  endfunction
  function automatic logic [DUR_W-1:0] phase_len(state_t st, logic [DUR_W-1:0] p1, p2, p3, p4);
    return (st == DOSE1) ? p1 : (st == DOSE2) ? p2 : (st == DOSE3) ? p3 : (st == SETTLE) ? p4 : '0;
  endfunction
  // Durations come straight from the inputs on the accepting cycle, from the latches afterwards
  always_comb begin
    a = (state == IDLE) ? bus.dur1 : d1;
    b = (state == IDLE) ? bus.dur2 : d2;
    c = (state == IDLE) ? bus.dur3 : d3;
    s = (state == IDLE) ? bus.settle : ds;
  end
  // Next phase: abort wins, zero-length phases are skipped, a phase ends when its count reaches 1
  always_comb begin
    accept  = state == IDLE && bus.start && !bus.abort;
    nxt     = (state != IDLE && bus.abort) ? IDLE :
              accept ? first_phase(IDLE, a, b, c, s) :
              (state == SAMPLE) ? IDLE :
              (state != IDLE && cnt == DUR_W'(1)) ? first_phase(state, a, b, c, s) : state;
    nxt_cnt = (nxt == state && state != IDLE) ? cnt - DUR_W'(1) : phase_len(nxt, a, b, c, s);
  end
  // State, counter, duration latches and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      d1                <= '0;
      d2                <= '0;
      d3                <= '0;
      ds                <= '0;
      bus.valve_soln1   <= 1'b0;
      bus.valve_soln2   <= 1'b0;
      bus.valve_soln3   <= 1'b0;
      bus.sample_strobe <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.aborted       <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      if (accept) begin
        d1 <= bus.dur1;
        d2 <= bus.dur2;
        d3 <= bus.dur3;
        ds <= bus.settle;
      end
      bus.valve_soln1   <= nxt == DOSE1;
      bus.valve_soln2   <= nxt == DOSE2;
      bus.valve_soln3   <= nxt == DOSE3;
      bus.sample_strobe <= nxt == SAMPLE;
      bus.busy          <= nxt != IDLE;
      bus.done          <= nxt == SAMPLE;
      bus.aborted       <= state != IDLE && bus.abort;
    end
  end
endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb_inlet_dose_sequencer: table-driven run scenarios checked cycle by cycle through an expected-output queue
module tb_inlet_dose_sequencer;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  inlet_dose_sequencer_if #(.DUR_W(DW)) bus ();
  inlet_dose_sequencer #(.DUR_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string name;
    int    d1, d2, d3, ds;
    int    abort_at, rst_at, chg2_at, start_at;
  } vec_t;
  vec_t       vecs[$];
  logic [6:0] sb[$];
  int         tests = 0;
  int         fails = 0;
  function automatic logic [6:0] outs();
    return {bus.valve_soln1, bus.valve_soln2, bus.valve_soln3, bus.sample_strobe,
            bus.busy, bus.done, bus.aborted};
  endfunction
  function automatic logic [6:0] expect_at(vec_t v, int k);
    int s = v.d1 + v.d2 + v.d3 + v.ds;
    if (v.abort_at > 0 && k > v.abort_at) return (k == v.abort_at + 1) ? 7'b0000001 : 7'b0;
    if (v.rst_at > 0 && k > v.rst_at) return 7'b0;
    return {k >= 1 && k <= v.d1,
            k > v.d1 && k <= v.d1 + v.d2,
            k > v.d1 + v.d2 && k <= v.d1 + v.d2 + v.d3,
            k == s + 1,
            k >= 1 && k <= s + 1,
            k == s + 1,
            1'b0};
  endfunction
  task automatic check(string name, int k);
    logic [6:0] e;
    e = sb.pop_front();
    tests++;
    if (outs() !== e) begin
      fails++;
      $display("FAIL %s cycle T+%0d: got v1v2v3/strobe/busy/done/aborted=%b want %b", name, k, outs(), e);
    end
  endtask
  task automatic run(vec_t v);
    int s;
    int len;
    s   = v.d1 + v.d2 + v.d3 + v.ds;
    len = s + 2;
    if (v.abort_at + 3 > len) len = v.abort_at + 3;
    if (v.rst_at + 3 > len) len = v.rst_at + 3;
    bus.dur1   = DW'(v.d1);
    bus.dur2   = DW'(v.d2);
    bus.dur3   = DW'(v.d3);
    bus.settle = DW'(v.ds);
    bus.start  = 1'b1;
    bus.abort  = 1'b0;
    for (int k = 1; k <= len; k++) begin
      sb.push_back(expect_at(v, k));
      @(posedge clk);
      #1;
      bus.start = (k == v.start_at);
      bus.abort = (k == v.abort_at);
      rst       = (k == v.rst_at);
      if (v.chg2_at > 0 && k >= v.chg2_at) bus.dur2 = DW'(9);
      check(v.name, k);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask
  initial begin
    vec_t bb;
    int   s;
    vecs.push_back('{"nominal",      3, 2, 4, 5, 0, 0, 0, 0});
    vecs.push_back('{"zero_skip",    0, 2, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"all_zero",     0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"abort_dose3",  3, 2, 4, 5, 7, 0, 0, 0});
    vecs.push_back('{"abort_settle", 1, 1, 1, 3, 4, 0, 0, 0});
    vecs.push_back('{"latch_inputs", 3, 2, 4, 5, 0, 0, 2, 4});
    vecs.push_back('{"reset_mid",    3, 2, 4, 5, 0, 5, 0, 0});
    vecs.push_back('{"after_reset",  3, 2, 4, 5, 0, 0, 0, 0});
    vecs.push_back('{"settle_only",  0, 0, 0, 3, 0, 0, 0, 0});
    vecs.push_back('{"soln3_only",   0, 0, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{"max_dur1",     (1 << DW) - 1, 0, 0, 0, 0, 0, 0, 0});
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.dur1   = '0;
    bus.dur2   = '0;
    bus.dur3   = '0;
    bus.settle = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(7'b0);
    check("reset_state", 0);
    rst = 1'b0;
    bus.dur1  = DW'(1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    sb.push_back(7'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_beats_start", 1);
    sb.push_back(7'b0);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_in_idle", 2);
    foreach (vecs[i]) run(vecs[i]);
    bb = '{"back_to_back", 2, 0, 0, 1, 0, 0, 0, 0};
    s  = bb.d1 + bb.d2 + bb.d3 + bb.ds;
    bus.dur1   = DW'(bb.d1);
    bus.dur2   = DW'(bb.d2);
    bus.dur3   = DW'(bb.d3);
    bus.settle = DW'(bb.ds);
    bus.start  = 1'b1;
    for (int k = 1; k <= 2 * (s + 2); k++) begin
      sb.push_back((k <= s + 2) ? expect_at(bb, k) : expect_at(bb, k - (s + 2)));
      @(posedge clk);
      #1;
      bus.start = (k <= s + 2);
      check(bb.name, k);
    end
    bus.start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inlet_dose_sequencer.md
INLET_DOSE_SEQUENCER -- requirements
Module: inlet_dose_sequencer

Interface
REQ-001 SHALL have parameter DUR_W, default 16, width of every duration field and the phase counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one dose run; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1: terminate any run in progress.
REQ-006 SHALL have ports dur1, dur2, dur3, input, DUR_W each: open-time in cycles for the soln1, soln2 and soln3 inlet valves.
REQ-007 SHALL have port settle, input, DUR_W: all-closed wait in cycles before sampling the out port.
REQ-008 SHALL have ports valve_soln1, valve_soln2, valve_soln3, output, 1 each: inlet valve open commands.
REQ-009 SHALL have port sample_strobe, output, 1: one-cycle pulse commanding the out-port detector to sample.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at run completion.
REQ-012 SHALL have port aborted, output, 1: one-cycle pulse when abort terminates a run.

Function
REQ-013 SHALL implement FSM states IDLE, DOSE1, DOSE2, DOSE3, SETTLE, SAMPLE.
REQ-014 SHALL drive all outputs from registers, with no combinational input-to-output path.
REQ-015 SHALL latch dur1, dur2, dur3 and settle on the cycle start is accepted; later input changes SHALL NOT affect the run.
REQ-016 SHALL accept start in IDLE when abort=0, and SHALL ignore start in every other state.
REQ-017 SHALL enter the first phase, in order DOSE1, DOSE2, DOSE3, SETTLE, SAMPLE, whose latched duration is nonzero; SAMPLE has no duration and is always entered.
REQ-018 SHALL use the same zero-skip rule at the exit of each phase, so a zero-duration phase occupies 0 cycles.
REQ-019 SHALL assert valve_solnN exactly in DOSEN cycles, with at most one valve high in any cycle.
REQ-020 SHALL hold each DOSE/SETTLE state for exactly its latched duration in cycles, counting down from the duration to 1 and exiting when the count is 1.
REQ-021 SHALL treat the maximum duration 2^DUR_W-1 without counter wrap.
REQ-022 SHALL hold SAMPLE for one cycle with sample_strobe=1 and done=1 in that cycle, then return to IDLE.
REQ-023 SHALL satisfy the latency rule: with start accepted at cycle T, sample_strobe is high at T+1+dur1+dur2+dur3+settle.
REQ-024 SHALL exit every non-IDLE state to IDLE on the next edge when abort=1, with all valves 0 from that edge, aborted=1 for one cycle, and no done or sample_strobe.
REQ-025 SHALL treat abort in IDLE as having no effect, with no aborted pulse.
REQ-026 SHALL give abort priority over start when both are high in IDLE: the run is not started and there is no aborted pulse.
REQ-027 SHALL accept a start arriving in the cycle after SAMPLE, since the FSM is in IDLE by then; back-to-back runs SHALL be legal.

Reset
REQ-028 SHALL on rst=1 go to IDLE at the next edge, regardless of state, including mid-dose.
REQ-029 SHALL on reset clear all valves, sample_strobe, busy, done, aborted and the counter to 0.
REQ-030 SHALL give rst priority over abort and start.
REQ-031 SHALL NOT emit an aborted pulse when reset interrupts a run.

Verification
REQ-032 Bench SHALL cover nominal timing: dur1=3, dur2=2, dur3=4, settle=5, start at T -> valve_soln1 high T+1..T+3, valve_soln2 high T+4..T+5, valve_soln3 high T+6..T+9, all valves low T+10..T+14, sample_strobe=done=1 at T+15, busy=0 at T+16.
REQ-033 Bench SHALL cover zero skip: dur1=0, dur2=2, dur3=0, settle=0 -> valve_soln2 high T+1..T+2, sample_strobe at T+3; all durations 0 -> sample_strobe at T+1.
REQ-034 Bench SHALL cover abort: same setup as REQ-032 with abort=1 at T+7 -> valve_soln3 low from T+8, aborted=1 at T+8, busy=0 at T+8, no done.
REQ-035 Bench SHALL cover input latching: dur2 changed to 9 at T+2 during a run started with dur2=2 -> valve_soln2 still high exactly 2 cycles; a start pulse during DOSE2 is ignored.
REQ-036 Bench SHALL cover reset mid-run: rst=1 at T+5 -> all outputs 0 at T+6, no aborted pulse; a start after rst deasserts gives nominal REQ-032 timing.
REQ-037 Bench SHALL cover back-to-back runs and the counter limit: start held high continuously -> second run's valve_soln1 rises 2 cycles after the first sample_strobe; dur1=2^DUR_W-1 -> valve_soln1 high for exactly that many cycles.
